pc_seq_ctrl: RTL and testbench

- Multicycle PC-sequencing FSM. It produces the 2-bit select consumed by the PC source mux, plus the PC/IR/EPC write strobes.
- It walks each instruction through fetch, decode, branch/jump resolution and exception entry.
- It sits between the instruction memory handshake and the datapath. It is the producer side of the PC mux select interface.

---
 rtl/pc_seq_ctrl_pkg.sv | 45 ++++
 rtl/pc_seq_ctrl_if.sv | 25 ++
 rtl/pc_seq_ctrl_fetch_timer.sv | 28 ++
 rtl/pc_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// rtl/pc_seq_ctrl_pkg.sv - opcode, state, pc_src and exception encodings for the PC sequencer
package pc_seq_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_BRANCH = 3'd3,
        ST_JUMP   = 3'd4,
        ST_EXC    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PCSRC_INC = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_JMP = 2'd2,
        PCSRC_EXC = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_ILLEGAL = 2'd1,
        EXC_OVF     = 2'd2,
        EXC_TIMEOUT = 2'd3
    } exc_cause_t;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_BNE)  || (op == OP_J);
    endfunction

    // Only R-type and addi trap on signed overflow; lw/sw address arithmetic never does.
    function automatic logic traps_ovf(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// rtl/pc_seq_ctrl_if.sv - memory handshake, datapath flags and PC/IR/EPC control bundle
interface pc_seq_if;
    logic       mem_ready;
    logic [5:0] opcode;
    logic       alu_zero;
    logic       alu_overflow;
    logic       exec_done;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       epc_write;
    logic [1:0] exc_cause;
    logic [2:0] state_dbg;

    modport master (
        input  mem_ready, opcode, alu_zero, alu_overflow, exec_done,
        output pc_src, pc_write, ir_write, mem_read, epc_write, exc_cause, state_dbg
    );

    modport slave (
        output mem_ready, opcode, alu_zero, alu_overflow, exec_done,
        input  pc_src, pc_write, ir_write, mem_read, epc_write, exc_cause, state_dbg
    );
endinterface

// File: rtl/pc_seq_ctrl_fetch_timer.sv
// rtl/pc_seq_ctrl_fetch_timer.sv - fetch wait counter with terminal count at TIMEOUT_CYCLES-1
module fetch_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);
    localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - multicycle PC sequencing FSM driving PC mux select and PC/IR/EPC strobes
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    pc_seq_if.master    bus
);
    state_t     state, state_nxt;
    exc_cause_t exc_q, exc_nxt;
    pc_src_t    src_c;
    logic       pw_c, iw_c, mr_c, ew_c;
    logic       tmr_clear, tmr_inc, tmr_tc;
    logic       taken;

    fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_fetch_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .inc   (tmr_inc),
        .tc    (tmr_tc)
    );

    assign taken = ((bus.opcode == OP_BEQ) &&  bus.alu_zero) ||
                   ((bus.opcode == OP_BNE) && !bus.alu_zero);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_FETCH;
            exc_q <= EXC_NONE;
        end else begin
            state <= state_nxt;
            exc_q <= exc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        exc_nxt   = exc_q;
        src_c     = PCSRC_INC;
        pw_c      = 1'b0;
        iw_c      = 1'b0;
        mr_c      = 1'b0;
        ew_c      = 1'b0;
        tmr_clear = 1'b0;
        tmr_inc   = 1'b0;
        case (state)
            ST_FETCH: begin
                mr_c = 1'b1;
                // A word arriving on the terminal cycle still counts as a good fetch.
                if (bus.mem_ready) begin
                    iw_c      = 1'b1;
                    pw_c      = 1'b1;
                    tmr_clear = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (tmr_tc) begin
                    exc_nxt   = EXC_TIMEOUT;
                    tmr_clear = 1'b1;
                    state_nxt = ST_EXC;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                if (!is_legal(bus.opcode)) begin
                    exc_nxt   = EXC_ILLEGAL;
                    state_nxt = ST_EXC;
                end else if (bus.opcode == OP_J) begin
                    state_nxt = ST_JUMP;
                end else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) begin
                    state_nxt = ST_BRANCH;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.exec_done) begin
                    if (traps_ovf(bus.opcode) && bus.alu_overflow) begin
                        exc_nxt   = EXC_OVF;
                        state_nxt = ST_EXC;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_BRANCH: begin
                if (taken) begin
                    pw_c  = 1'b1;
                    src_c = PCSRC_BR;
                end
                state_nxt = ST_FETCH;
            end
            ST_JUMP: begin
                pw_c      = 1'b1;
                src_c     = PCSRC_JMP;
                state_nxt = ST_FETCH;
            end
            ST_EXC: begin
                ew_c      = 1'b1;
                pw_c      = 1'b1;
                src_c     = PCSRC_EXC;
                state_nxt = ST_FETCH;
            end
            default: begin
                tmr_clear = 1'b1;
                state_nxt = ST_FETCH;
            end
        endcase
    end

    // Strobes are masked by reset so nothing is written while the sequencer is held.
    assign bus.pc_write  = reset & pw_c;
    assign bus.ir_write  = reset & iw_c;
    assign bus.mem_read  = reset & mr_c;
    assign bus.epc_write = reset & ew_c;
    assign bus.pc_src    = (reset & pw_c) ? src_c : PCSRC_INC;
    assign bus.exc_cause = exc_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - scoreboard bench for pc_seq_ctrl with directed per-cycle vectors
module tb_pc_seq_ctrl;

    typedef struct {
        logic [10:0] v;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    pc_seq_if intf ();

    pc_seq_ctrl #(
        .TIMEOUT_CYCLES (16),
        .TMR_W          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ex(input logic [2:0] st, input logic [1:0] ec,
                                       input logic [1:0] src, input logic pw, input logic iw,
                                       input logic mr, input logic ew);
        return {st, ec, src, pw, iw, mr, ew};
    endfunction

    task automatic chk(input logic [10:0] v, input string name);
        exp_t e;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [10:0] act;
            e   = sb.pop_front();
            act = {intf.state_dbg, intf.exc_cause, intf.pc_src, intf.pc_write,
                   intf.ir_write, intf.mem_read, intf.epc_write};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got st=%0d exc=%0d src=%0d pw=%b iw=%b mr=%b ew=%b, expected st=%0d exc=%0d src=%0d pw=%b iw=%b mr=%b ew=%b",
                         e.name, act[10:8], act[7:6], act[5:4], act[3], act[2], act[1], act[0],
                         e.v[10:8], e.v[7:6], e.v[5:4], e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b0;
        intf.mem_ready    = 1'b0;
        intf.opcode       = 6'h00;
        intf.alu_zero     = 1'b0;
        intf.alu_overflow = 1'b0;
        intf.exec_done    = 1'b0;
        @(posedge clk);
        #1;
        chk(ex(0, 0, 0, 0, 0, 0, 0), "reset_hold0");
        chk(ex(0, 0, 0, 0, 0, 0, 0), "reset_hold1");

        reset = 1'b1; intf.mem_ready = 1'b1;
        chk(ex(0, 0, 0, 1, 1, 1, 0), "first_fetch");
        intf.mem_ready = 1'b0; intf.opcode = 6'h04; intf.alu_zero = 1'b1;
        chk(ex(1, 0, 0, 0, 0, 0, 0), "decode_beq");
        chk(ex(3, 0, 1, 1, 0, 0, 0), "beq_taken");

        intf.mem_ready = 1'b1;
        chk(ex(0, 0, 0, 1, 1, 1, 0), "fetch_b2");
        intf.mem_ready = 1'b0; intf.alu_zero = 1'b0;
        chk(ex(1, 0, 0, 0, 0, 0, 0), "decode_beq2");
        chk(ex(3, 0, 0, 0, 0, 0, 0), "beq_not_taken");

        intf.mem_ready = 1'b1;
        chk(ex(0, 0, 0, 1, 1, 1, 0), "fetch_bne");
        intf.mem_ready = 1'b0; intf.opcode = 6'h05;
        chk(ex(1, 0, 0, 0, 0, 0, 0), "decode_bne");
        chk(ex(3, 0, 1, 1, 0, 0, 0), "bne_taken");

        intf.mem_ready = 1'b1;
        chk(ex(0, 0, 0, 1, 1, 1, 0), "fetch_j");
        intf.mem_ready = 1'b0; intf.opcode = 6'h02;
        chk(ex(1, 0, 0, 0, 0, 0, 0), "decode_j");
        chk(ex(4, 0, 2, 1, 0, 0, 0), "jump");

        intf.mem_ready = 1'b1;
        chk(ex(0, 0, 0, 1, 1, 1, 0), "fetch_after_jump");
        intf.mem_ready = 1'b0; intf.opcode = 6'h3F;
        chk(ex(1, 0, 0, 0, 0, 0, 0), "decode_illegal");
        chk(ex(5, 1, 3, 1, 0, 0, 1), "exc_illegal");
        chk(ex(0, 1, 0, 0, 0, 1, 0), "exc_cause_hold");
        intf.mem_ready = 1'b1;
        chk(ex(0, 1, 0, 1, 1, 1, 0), "fetch_rtype");

        intf.mem_ready = 1'b0; intf.opcode = 6'h00;
        chk(ex(1, 1, 0, 0, 0, 0, 0), "decode_rtype");
        for (int i = 0; i < 4; i++) chk(ex(2, 1, 0, 0, 0, 0, 0), "exec_wait");
        intf.exec_done = 1'b1; intf.alu_overflow = 1'b1;
        chk(ex(2, 1, 0, 0, 0, 0, 0), "exec_done_ovf");
        intf.exec_done = 1'b0; intf.alu_overflow = 1'b0;
        chk(ex(5, 2, 3, 1, 0, 0, 1), "exc_ovf");

        for (int i = 0; i < 16; i++) chk(ex(0, 2, 0, 0, 0, 1, 0), "tmo_wait");
        chk(ex(5, 3, 3, 1, 0, 0, 1), "exc_timeout");

        for (int i = 0; i < 7; i++) chk(ex(0, 3, 0, 0, 0, 1, 0), "pre_reset_wait");
        reset = 1'b0;
        chk(ex(0, 3, 0, 0, 0, 0, 0), "reset_mid_fetch");
        reset = 1'b1;
        for (int i = 0; i < 16; i++) chk(ex(0, 0, 0, 0, 0, 1, 0), "fresh_window");
        chk(ex(5, 3, 3, 1, 0, 0, 1), "exc_timeout2");

        for (int i = 0; i < 15; i++) chk(ex(0, 3, 0, 0, 0, 1, 0), "race_wait");
        intf.mem_ready = 1'b1;
        chk(ex(0, 3, 0, 1, 1, 1, 0), "ready_wins");
        intf.mem_ready = 1'b0; intf.opcode = 6'h23;
        chk(ex(1, 3, 0, 0, 0, 0, 0), "decode_lw");
        intf.exec_done = 1'b1; intf.alu_overflow = 1'b1;
        chk(ex(2, 3, 0, 0, 0, 0, 0), "lw_exec");
        intf.exec_done = 1'b0; intf.alu_overflow = 1'b0;
        chk(ex(0, 3, 0, 0, 0, 1, 0), "lw_no_exc");

        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
